muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for the single-cycle MIPS datapath; sits directly
//  downstream of registerfile32 and consumes its rd1/rd2 read ports as operands a/b.
//  Executes MULT, MULTU, DIV and DIVU over several cycles, and holds the architectural HI/LO pair.
//  Serves MFHI/MFLO reads and MTHI/MTLO writes. The controller stalls the PC while busy=1.
// PARAMETERS
//  WIDTH     32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
//  CNT_W      6  counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1      rising-edge clock, single clock domain
//  reset         in   1      asynchronous, active-low reset (0 = reset)
//  start         in   1      1-cycle request; sampled only in IDLE
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a             in   WIDTH  operand rs (rd1); multiplicand / dividend
//  b             in   WIDTH  operand rt (rd2); multiplier / divisor
//  hi_we         in   1      MTHI write strobe
//  lo_we         in   1      MTLO write strobe
//  wd            in   WIDTH  MTHI/MTLO write data
//  busy          out  1      1 while an operation is in flight
//  done          out  1      1-cycle pulse: hi/lo hold the new result
//  div_by_zero   out  1      1-cycle pulse with done when a DIV/DIVU had b==0
//  hi            out  WIDTH  HI register (MULT: upper product; DIV: remainder)
//  lo            out  WIDTH  LO register (MULT: lower product; DIV: quotient)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy, done, div_by_zero, hi, lo = 0;
//    counter = 0. An operation in flight is discarded.
//  - FSM IDLE -> RUN -> IDLE:
//    IDLE: start=1 latches op, |a|, |b|, and the sign flags; busy=1 from the next cycle.
//    RUN: one shift-add (mult) or restoring shift-subtract (div) step per clock, WIDTH steps.
//    After the last step: write hi/lo, pulse done for 1 cycle, busy=0, return to IDLE.
//  - Latency: start sampled at edge E0 -> busy=1 for cycles E0..E(WIDTH) -> hi/lo valid and
//    done=1 after edge E(WIDTH). A new start is legal in the done cycle.
//  - Signed ops: operate on magnitudes, then apply the signs.
//    Product is negated (2*WIDTH-bit) if the operand signs differ.
//    Quotient is negated if the signs differ; remainder takes the dividend's sign.
//    MULTU/DIVU: no sign handling.
//  - -2^31 / -1 (DIV): quotient wraps to 0x80000000, remainder 0; no trap.
//  - Divide by zero: no iteration; completes after E1 with done=1 and div_by_zero=1.
//    hi/lo are unchanged.
//  - start while busy: ignored (no queueing, no error).
//  - hi_we/lo_we: write wd at the edge, in IDLE only; ignored while busy.
//    hi_we and lo_we together write both registers.
//  - hi_we/lo_we in the same cycle as start: start wins and the write is dropped.
//  - hi/lo change only on reset, on operation completion, or on an accepted MTHI/MTLO.
//  - op, a and b are don't-care after the start cycle (internal copies are used).
// CONFIGURATION
//  FAST_MULT_EN defined: MULT/MULTU use the combinational '*' and complete after E1
//    (busy for 1 cycle, done after E1). DIV/DIVU are unchanged (WIDTH cycles).
//  FAST_MULT_EN undefined: all ops are iterative as above; no hardware multiplier is inferred.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done after 32 cycles; hi=0xFFFFFFFE lo=0x00000001
//  2 MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB;
//    FAST_MULT_EN build: same result with done 1 cycle after start
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//    DIVU a=100 b=7 -> lo=14 hi=2
//  4 DIV b=0 after MTHI 0x1234 / MTLO 0x5678 -> done+div_by_zero after 1 cycle;
//    hi=0x1234 lo=0x5678 kept
//  5 start MULTU 5*6, then re-pulse start and hi_we (wd=0xDEAD) mid-run ->
//    ignored; hi=0 lo=30 at cycle 32
//  6 reset=0 at cycle 10 of a DIVU -> busy=0, hi=lo=0 immediately (async);
//    after release, a new DIVU 9/3 gives lo=3 hi=0

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, MTHI/MTLO.
// Optional macro FAST_MULT_EN: MULT/MULTU use a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic is_div;
    logic dz;
    logic sgn_q;  // negate product / quotient
    logic sgn_r;  // negate remainder
  } req_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  req_t               req;
  logic [WIDTH-1:0]   opnd;   // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0] acc;    // {partial product | remainder, multiplier | quotient}
  logic [CNT_W-1:0]   cnt;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               last_step, finish;

  logic [WIDTH:0]     msum, dsh, ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, mul_raw, prod_fin;
  logic [WIDTH-1:0]   q_fin, r_fin;

  always_comb begin
    sa    = ~op[0] & a[WIDTH-1];
    sb    = ~op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One iteration step of each algorithm; only the one matching req.is_div is kept.
  always_comb begin
    msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_nxt = {msum, acc[WIDTH-1:1]};
    dsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ddiff   = dsh - {1'b0, opnd};
    dge     = ~ddiff[WIDTH];
    div_nxt = {(dge ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0]), acc[WIDTH-2:0], dge};
    acc_nxt = req.is_div ? div_nxt : mul_nxt;
  end

`ifdef FAST_MULT_EN
  assign mul_raw   = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
  assign last_step = req.dz | ~req.is_div | (cnt == LAST);
`else
  assign mul_raw   = mul_nxt;
  assign last_step = req.dz | (cnt == LAST);
`endif

  always_comb begin
    prod_fin = req.sgn_q ? -mul_raw : mul_raw;
    q_fin    = req.sgn_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    r_fin    = req.sgn_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
  end

  assign finish = (state == RUN) & last_step;
  assign busy   = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req         <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          req.is_div <= op[1];
          req.dz     <= op[1] & (b == '0);
          req.sgn_q  <= sa ^ sb;
          req.sgn_r  <= sa;
          opnd       <= op[1] ? mag_b : mag_a;
          acc        <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          cnt        <= '0;
        end else begin
          // start takes priority over a same-cycle MTHI/MTLO
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
        if (finish) begin
          done        <= 1'b1;
          div_by_zero <= req.dz;
          if (!req.dz) begin
            if (req.is_div) {hi, lo} <= {r_fin, q_fin};
            else            {hi, lo} <= prod_fin;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected HI/LO/div_by_zero/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 32;
`endif

  logic        clk, reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wd, hi, lo;
  logic        busy, done, div_by_zero;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 at cyc %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result_hi", hi, mon_e.hi);
        chk("result_lo", lo, mon_e.lo);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, mon_e.dbz});
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge; returns one negedge after the start cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez,
                       input int lat);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; reset = 0; start = 0; op = 0; a = 0; b = 0;
    hi_we = 0; lo_we = 0; wd = 0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1;
    @(negedge clk);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MLAT);
    wait_done();
    // back-to-back: each start lands in the previous done cycle
    issue(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MLAT);
    wait_done();
    issue(MULT,  32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 32'h00000014, 1'b0, MLAT);
    wait_done();
    issue(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32);
    chk("div_busy", {31'b0, busy}, 32'd1);
    wait_done();
    issue(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32);
    wait_done();
    issue(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32);
    wait_done();
    issue(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32);
    wait_done();

    hi_we = 1; lo_we = 1; wd = 32'hA5A55A5A;
    @(negedge clk); hi_we = 0; lo_we = 0;
    chk("mt_both_hi", hi, 32'hA5A55A5A);
    chk("mt_both_lo", lo, 32'hA5A55A5A);
    hi_we = 1; wd = 32'h1234;
    @(negedge clk); hi_we = 0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'hA5A55A5A);
    lo_we = 1; wd = 32'h5678;
    @(negedge clk); lo_we = 0;
    chk("mtlo_lo", lo, 32'h5678);

    issue(DIV, 32'h55, 32'd0, 32'h1234, 32'h5678, 1'b1, 1);
    wait_done();

    issue(MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, MLAT);
`ifndef FAST_MULT_EN
    repeat (4) @(negedge clk);
    start = 1; op = DIVU; a = 32'd1; b = 32'd1; hi_we = 1; wd = 32'hDEAD;
    @(negedge clk); start = 0; hi_we = 0;
    chk("midrun_hi_kept", hi, 32'h1234);
    chk("midrun_busy", {31'b0, busy}, 32'd1);
`endif
    wait_done();

    // asynchronous reset in the middle of a DIVU
    issue(DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 32);
    repeat (9) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    sb.delete();
    @(negedge clk); reset = 1;
    repeat (40) @(negedge clk);

    // MTHI/MTLO in the start cycle are dropped
    hi_we = 1; lo_we = 1; wd = 32'hFFFFFFFF;
    issue(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32);
    chk("start_wins_hi", hi, 32'd0);
    chk("start_wins_lo", lo, 32'd0);
    wait_done();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
